// File: rtl/conversor_binario_bcd_if.sv
// Bus between a binary value source and the BCD converter.
// master drives start/sinal/dado; slave returns bcd/negativo/busy/done.
interface conversor_binario_bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic                  sinal;
  logic [WIDTH-1:0]      dado;
  logic [4*DIGITS-1:0]   bcd;
  logic                  negativo;
  logic                  busy;
  logic                  done;

  modport master (
    output start, sinal, dado,
    input  bcd, negativo, busy, done
  );

  modport slave (
    input  start, sinal, dado,
    output bcd, negativo, busy, done
  );
endinterface

// File: rtl/conversor_binario_bcd.sv
// Sequential binary-to-BCD converter (double dabble), WIDTH steps per value.
// Ports: clock, reset (async high), bus (slave: start/sinal/dado in; bcd/negativo/busy/done out).
module conversor_binario_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic clock,
  input  logic reset,
  conversor_binario_bcd_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    scr_q, scr_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             negativo_q, negativo_d;

  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] sh;

  // Per-nibble add-3; nibbles never carry into each other.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    sh = {adj, mag_q} << 1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      scr_q      <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      bcd_q      <= '0;
      negativo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scr_q      <= scr_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      bcd_q      <= bcd_d;
      negativo_q <= negativo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scr_d      = scr_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    bcd_d      = bcd_q;
    negativo_d = negativo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          neg_d   = bus.sinal & bus.dado[WIDTH-1];
          // -2^(WIDTH-1) negates to itself, which is the
          // right magnitude read as unsigned.
          mag_d   = neg_d ? -bus.dado : bus.dado;
          scr_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = sh[BW+WIDTH-1:WIDTH];
        mag_d = sh[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d      = sh[BW+WIDTH-1:WIDTH];
          negativo_d = neg_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.bcd      = bcd_q;
    bus.negativo = negativo_q;
    bus.busy     = (state_q == SHIFT);
    bus.done     = (state_q == DONE);
  end

endmodule
